// File: rtl/cg_phase_sequencer.sv
// cg_phase_sequencer
//   Phase scheduler for one conjugate-gradient solver run. Walks the
//   INIT_RR -> MATVEC -> DOT_PAP -> ALPHA -> UPD_XR -> DOT_RR -> CHECK loop,
//   with BETA -> UPD_P closing each non-final iteration. Each active phase
//   fires a one-cycle start at its engine and waits for that engine's done.
//   Addressing belongs to the engines; this block only orders them.
//
// Ports
//   clk, reset            clock, async active-high reset
//   start, abort          run request (IDLE/DONE/ERROR only), synchronous abort
//   total                 vector length, latched on an accepted start
//   converged             residual flag, sampled when DOT_RR completes
//   mv_*, dot_*, div_*,   engine start pulses / done inputs and operand selects
//   upd_*
//   block_count           total / NO_OF_UNITS captured at start
//   phase, iteration      current state encoding, completed iterations
//   busy, done, halt,     run status
//   error, conv_hit
module cg_phase_sequencer #(
    parameter int NO_OF_UNITS    = 8,
    parameter int MAX_ITER       = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ITER_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       total,
    input  logic              converged,
    output logic              mv_start,
    input  logic              mv_done,
    output logic              dot_start,
    input  logic              dot_done,
    output logic              dot_sel,
    output logic              div_start,
    input  logic              div_done,
    output logic              div_sel,
    output logic              upd_start,
    input  logic              upd_done,
    output logic              upd_sel,
    output logic [31:0]       block_count,
    output logic [3:0]        phase,
    output logic [ITER_W-1:0] iteration,
    output logic              busy,
    output logic              done,
    output logic              halt,
    output logic              error,
    output logic              conv_hit
);

    localparam int SHIFT  = $clog2(NO_OF_UNITS);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_INIT_RR = 4'd1;
    localparam logic [3:0] S_MATVEC  = 4'd2;
    localparam logic [3:0] S_DOT_PAP = 4'd3;
    localparam logic [3:0] S_ALPHA   = 4'd4;
    localparam logic [3:0] S_UPD_XR  = 4'd5;
    localparam logic [3:0] S_DOT_RR  = 4'd6;
    localparam logic [3:0] S_CHECK   = 4'd7;
    localparam logic [3:0] S_BETA    = 4'd8;
    localparam logic [3:0] S_UPD_P   = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;
    localparam logic [3:0] S_ERROR   = 4'd11;

    localparam logic [ITER_W-1:0] MAX_ITER_V  = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] LAST_ITER_V = ITER_W'(MAX_ITER - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V   = WAIT_W'(TIMEOUT_CYCLES);

    logic [3:0]        state_q, state_d;
    logic [31:0]       blk_q, blk_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              halt_q, halt_d;
    logic              conv_q, conv_d;
    logic              armed_q, armed_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mv_start_q, mv_start_d;
    logic              dot_start_q, dot_start_d;
    logic              div_start_q, div_start_d;
    logic              upd_start_q, upd_start_d;

    logic              is_active;
    logic              eng_done;
    logic [3:0]        nxt_ok;
    logic              accept;
    logic              timeout;
    logic              can_start;
    logic              enter;
    logic [31:0]       new_blk;

    assign new_blk = total >> SHIFT;

    // Which engine owns the current state and where its done leads.
    always_comb begin
        is_active = 1'b0;
        eng_done  = 1'b0;
        nxt_ok    = S_IDLE;
        case (state_q)
            S_INIT_RR: begin is_active = 1'b1; eng_done = dot_done; nxt_ok = S_MATVEC;  end
            S_MATVEC:  begin is_active = 1'b1; eng_done = mv_done;  nxt_ok = S_DOT_PAP; end
            S_DOT_PAP: begin is_active = 1'b1; eng_done = dot_done; nxt_ok = S_ALPHA;   end
            S_ALPHA:   begin is_active = 1'b1; eng_done = div_done; nxt_ok = S_UPD_XR;  end
            S_UPD_XR:  begin is_active = 1'b1; eng_done = upd_done; nxt_ok = S_DOT_RR;  end
            S_DOT_RR:  begin is_active = 1'b1; eng_done = dot_done; nxt_ok = S_CHECK;   end
            S_BETA:    begin is_active = 1'b1; eng_done = div_done; nxt_ok = S_UPD_P;   end
            S_UPD_P:   begin is_active = 1'b1; eng_done = upd_done; nxt_ok = S_MATVEC;  end
            default:   ;
        endcase
    end

    // armed_q only rises after the start pulse has gone out, so a done that
    // coincides with its own start is never taken.
    assign accept    = is_active && armed_q && eng_done;
    assign timeout   = is_active && (wait_q == TIMEOUT_V);
    assign can_start = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);

    // Branch order encodes precedence: abort > timeout > done > start.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        iter_d  = iter_q;
        halt_d  = halt_q;
        conv_d  = conv_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            halt_d  = 1'b0;
            conv_d  = 1'b0;
        end else if (timeout) begin
            state_d = S_ERROR;
        end else if (accept) begin
            state_d = nxt_ok;
            if (state_q == S_DOT_RR) conv_d = converged;
        end else if (state_q == S_CHECK) begin
            if (conv_q) begin
                state_d = S_DONE;
            end else begin
                iter_d = (iter_q == MAX_ITER_V) ? iter_q : iter_q + ITER_W'(1);
                if (iter_q == LAST_ITER_V) begin
                    halt_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_BETA;
                end
            end
        end else if (start && can_start) begin
            blk_d   = new_blk;
            iter_d  = '0;
            halt_d  = 1'b0;
            conv_d  = 1'b0;
            state_d = (new_blk == 32'd0) ? S_ERROR : S_INIT_RR;
        end
    end

    // Start pulses are registered on the entering edge, so they occupy
    // exactly the first cycle of the new state.
    always_comb begin
        enter       = (state_d != state_q);
        mv_start_d  = enter && (state_d == S_MATVEC);
        dot_start_d = enter && ((state_d == S_INIT_RR) || (state_d == S_DOT_PAP) ||
                                (state_d == S_DOT_RR));
        div_start_d = enter && ((state_d == S_ALPHA) || (state_d == S_BETA));
        upd_start_d = enter && ((state_d == S_UPD_XR) || (state_d == S_UPD_P));
        armed_d     = enter ? 1'b0
                            : (armed_q | mv_start_q | dot_start_q | div_start_q | upd_start_q);
        wait_d      = (enter || !is_active) ? '0 : wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            iter_q      <= '0;
            halt_q      <= 1'b0;
            conv_q      <= 1'b0;
            armed_q     <= 1'b0;
            wait_q      <= '0;
            mv_start_q  <= 1'b0;
            dot_start_q <= 1'b0;
            div_start_q <= 1'b0;
            upd_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            iter_q      <= iter_d;
            halt_q      <= halt_d;
            conv_q      <= conv_d;
            armed_q     <= armed_d;
            wait_q      <= wait_d;
            mv_start_q  <= mv_start_d;
            dot_start_q <= dot_start_d;
            div_start_q <= div_start_d;
            upd_start_q <= upd_start_d;
        end
    end

    assign mv_start    = mv_start_q;
    assign dot_start   = dot_start_q;
    assign div_start   = div_start_q;
    assign upd_start   = upd_start_q;
    assign dot_sel     = (state_q == S_INIT_RR) || (state_q == S_DOT_RR);
    assign div_sel     = (state_q == S_BETA);
    assign upd_sel     = (state_q == S_UPD_P);
    assign block_count = blk_q;
    assign phase       = state_q;
    assign iteration   = iter_q;
    assign busy        = is_active || (state_q == S_CHECK);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign halt        = halt_q;
    assign conv_hit    = conv_q;

endmodule

// File: tb/tb_cg_phase_sequencer.sv
module tb_cg_phase_sequencer;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] total = 32'd0;
    logic        converged = 1'b0;
    logic        mv_start, dot_start, div_start, upd_start;
    logic        mv_done, dot_done, div_done, upd_done;
    logic        dot_sel, div_sel, upd_sel;
    logic [31:0] block_count;
    logic [3:0]  phase;
    logic [15:0] iteration;
    logic        busy, done, halt, error, conv_hit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cg_phase_sequencer #(
        .NO_OF_UNITS(8), .MAX_ITER(3), .TIMEOUT_CYCLES(TMO), .ITER_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .total(total),
        .converged(converged),
        .mv_start(mv_start), .mv_done(mv_done),
        .dot_start(dot_start), .dot_done(dot_done), .dot_sel(dot_sel),
        .div_start(div_start), .div_done(div_done), .div_sel(div_sel),
        .upd_start(upd_start), .upd_done(upd_done), .upd_sel(upd_sel),
        .block_count(block_count), .phase(phase), .iteration(iteration),
        .busy(busy), .done(done), .halt(halt), .error(error), .conv_hit(conv_hit)
    );

    // Engine models: done pulses 3 cycles after start, or (hold_mode) stays
    // high from the start cycle onwards. withhold_div silences the divider.
    logic [3:0] eng_start;
    logic [3:0] eng_done = 4'd0;
    int         cnt[4] = '{0, 0, 0, 0};
    logic       held[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       hold_mode = 1'b0;
    logic       withhold_div = 1'b0;
    logic       rsp_pulse;

    assign eng_start = {upd_start, div_start, dot_start, mv_start};
    assign mv_done   = eng_done[0];
    assign dot_done  = eng_done[1];
    assign div_done  = eng_done[2];
    assign upd_done  = eng_done[3];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rsp_pulse = 1'b0;
            if (reset) begin
                cnt[i]  = 0;
                held[i] = 1'b0;
            end else if (eng_start[i]) begin
                cnt[i]  = 3;
                held[i] = hold_mode;
            end else if (cnt[i] != 0) begin
                cnt[i]    = cnt[i] - 1;
                rsp_pulse = (cnt[i] == 0);
            end
            if (!hold_mode) held[i] = 1'b0;
            eng_done[i] = (hold_mode ? held[i] : rsp_pulse) && !(i == 2 && withhold_div);
        end
    end

    // Monitor: phase change log, start pulse accounting, converged driver.
    logic [3:0] phase_log[$];
    logic [3:0] last_phase = 4'd0;
    logic [3:0] prev_phase = 4'd0;
    logic [3:0] prev_start = 4'd0;
    int mv_cnt = 0, starts_cnt = 0, drr_cnt = 0, width_err = 0, adv_err = 0;
    int clr_req = 0, clr_seen = 0, conv_on_drr = 0;

    always @(negedge clk) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            phase_log.delete();
            mv_cnt = 0; starts_cnt = 0; drr_cnt = 0; width_err = 0; adv_err = 0;
        end
        if (phase != last_phase) begin
            phase_log.push_back(phase);
            last_phase = phase;
        end
        if (mv_start) mv_cnt++;
        if (eng_start != 4'd0) starts_cnt++;
        if ((eng_start & prev_start) != 4'd0) width_err++;
        if (prev_start != 4'd0 && phase != prev_phase) adv_err++;
        if (dot_start && phase == 4'd6) drr_cnt++;
        converged  = (conv_on_drr != 0) && (drr_cnt >= conv_on_drr);
        prev_start = eng_start;
        prev_phase = phase;
    end

    task automatic mon_clear();
        #1;
        clr_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] t);
        @(negedge clk);
        total = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done || error) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [12:0] flags;
        repeat (2) @(negedge clk);
        flags = {phase, busy, done, halt, error, conv_hit, mv_start, dot_start, div_start, upd_start};
        checks++;
        if (flags !== 13'd0 || {dot_sel, div_sel, upd_sel} !== 3'd0) begin
            errors++; $display("FAIL reset_flags: got %h/%b want 0/000", flags, {dot_sel, div_sel, upd_sel});
        end
        checks++;
        if (block_count !== 32'd0 || iteration !== 16'd0) begin
            errors++; $display("FAIL reset_counts: got blk=%0d it=%0d want 0/0", block_count, iteration);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (phase !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got phase=%0d busy=%b want 0/0", phase, busy);
        end
    endtask

    task automatic test_converge();
        logic [3:0] exp_q[$];
        int bad;
        bit ok;
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                  4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
        conv_on_drr = 2;
        mon_clear();
        do_start(32'd64);
        checks++;
        if (phase !== 4'd1 || busy !== 1'b1 || dot_start !== 1'b1 || dot_sel !== 1'b1) begin
            errors++; $display("FAIL start_latency: got phase=%0d busy=%b dot_start=%b sel=%b want 1/1/1/1",
                               phase, busy, dot_start, dot_sel);
        end
        checks++;
        if (block_count !== 32'd8) begin
            errors++; $display("FAIL block_count64: got %0d want 8", block_count);
        end
        wait_end(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL conv_timeout: got no done want done within 400"); end
        @(negedge clk); #1;
        bad = (phase_log.size() != exp_q.size()) ? 99 : -1;
        if (bad < 0)
            for (int i = 0; i < exp_q.size(); i++)
                if (phase_log[i] !== exp_q[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL conv_phase_seq: got len=%0d first_bad=%0d want 16 entries 1..9,2..7,10",
                               phase_log.size(), bad);
        end
        checks++;
        if (iteration !== 16'd1 || conv_hit !== 1'b1 || halt !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL conv_status: got it=%0d conv=%b halt=%b done=%b busy=%b want 1/1/0/1/0",
                               iteration, conv_hit, halt, done, busy);
        end
    endtask

    task automatic test_max_iter();
        bit ok;
        conv_on_drr = 0;
        mon_clear();
        do_start(32'd64);
        wait_end(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL maxit_timeout: got no done want done within 1000"); end
        @(negedge clk); #1;
        checks++;
        if (iteration !== 16'd3 || halt !== 1'b1 || conv_hit !== 1'b0 || phase !== 4'd10) begin
            errors++; $display("FAIL maxit_status: got it=%0d halt=%b conv=%b phase=%0d want 3/1/0/10",
                               iteration, halt, conv_hit, phase);
        end
        checks++;
        if (mv_cnt != 3) begin
            errors++; $display("FAIL maxit_mv_pulses: got %0d want 3", mv_cnt);
        end
    endtask

    task automatic test_hold_done();
        logic [3:0] exp_q[$];
        int bad;
        bit ok;
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
        hold_mode = 1'b1;
        conv_on_drr = 1;
        mon_clear();
        do_start(32'd64);
        wait_end(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_timeout: got no done want done within 200"); end
        @(negedge clk); #1;
        bad = (phase_log.size() != exp_q.size()) ? 99 : -1;
        if (bad < 0)
            for (int i = 0; i < exp_q.size(); i++)
                if (phase_log[i] !== exp_q[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL hold_phase_seq: got len=%0d first_bad=%0d want 1..7,10", phase_log.size(), bad);
        end
        checks++;
        if (width_err != 0 || adv_err != 0) begin
            errors++; $display("FAIL hold_start_rules: got wide=%0d early_adv=%0d want 0/0", width_err, adv_err);
        end
        checks++;
        if (iteration !== 16'd0 || conv_hit !== 1'b1) begin
            errors++; $display("FAIL hold_status: got it=%0d conv=%b want 0/1", iteration, conv_hit);
        end
        hold_mode = 1'b0;
        conv_on_drr = 0;
    endtask

    task automatic test_timeout();
        withhold_div = 1'b1;
        conv_on_drr = 0;
        do_start(32'd64);
        for (int k = 0; k < 100 && phase != 4'd4; k++) @(negedge clk);
        checks++;
        if (phase !== 4'd4) begin errors++; $display("FAIL tmo_reach_alpha: got phase=%0d want 4", phase); end
        repeat (TMO) @(negedge clk);
        checks++;
        if (phase !== 4'd4 || error !== 1'b0) begin
            errors++; $display("FAIL tmo_early: got phase=%0d err=%b want 4/0", phase, error);
        end
        @(negedge clk);
        checks++;
        if (phase !== 4'd11 || error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_error: got phase=%0d err=%b busy=%b want 11/1/0", phase, error, busy);
        end
        withhold_div = 1'b0;
        do_start(32'd16);
        checks++;
        if (phase !== 4'd1 || block_count !== 32'd2 || error !== 1'b0 || dot_start !== 1'b1) begin
            errors++; $display("FAIL tmo_restart: got phase=%0d blk=%0d err=%b dot_start=%b want 1/2/0/1",
                               phase, block_count, error, dot_start);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (phase !== 4'd0) begin errors++; $display("FAIL tmo_abort_idle: got phase=%0d want 0", phase); end
    endtask

    task automatic test_zero_blocks();
        repeat (6) @(negedge clk);
        mon_clear();
        do_start(32'd4);
        checks++;
        if (phase !== 4'd11 || error !== 1'b1 || busy !== 1'b0 || eng_start !== 4'd0 || block_count !== 32'd0) begin
            errors++; $display("FAIL zero_blk: got phase=%0d err=%b busy=%b starts=%b blk=%0d want 11/1/0/0000/0",
                               phase, error, busy, eng_start, block_count);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (starts_cnt != 0) begin errors++; $display("FAIL zero_blk_starts: got %0d want 0", starts_cnt); end
    endtask

    task automatic test_async_reset();
        logic [12:0] flags;
        conv_on_drr = 0;
        do_start(32'd64);
        for (int k = 0; k < 300 && !(phase == 4'd5 && iteration == 16'd1); k++) @(negedge clk);
        checks++;
        if (phase !== 4'd5 || iteration !== 16'd1) begin
            errors++; $display("FAIL areset_reach: got phase=%0d it=%0d want 5/1", phase, iteration);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        flags = {phase, busy, done, halt, error, conv_hit, mv_start, dot_start, div_start, upd_start};
        checks++;
        if (flags !== 13'd0 || block_count !== 32'd0 || iteration !== 16'd0) begin
            errors++; $display("FAIL areset_now: got flags=%h blk=%0d it=%0d want 0/0/0", flags, block_count, iteration);
        end
        #3;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (phase !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_after: got phase=%0d busy=%b want 0/0", phase, busy);
        end
    endtask

    task automatic test_abort();
        repeat (6) @(negedge clk);
        do_start(32'd64);
        for (int k = 0; k < 50 && phase != 4'd2; k++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (phase !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || eng_start !== 4'd0 || iteration !== 16'd0) begin
            errors++; $display("FAIL abort_idle: got phase=%0d busy=%b done=%b starts=%b it=%0d want 0/0/0/0000/0",
                               phase, busy, done, eng_start, iteration);
        end
        mon_clear();
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (starts_cnt != 0 || phase !== 4'd0) begin
            errors++; $display("FAIL abort_quiet: got starts=%0d phase=%0d want 0/0", starts_cnt, phase);
        end
    endtask

    initial begin
        test_reset();
        test_converge();
        test_max_iter();
        test_hold_done();
        test_timeout();
        test_zero_blocks();
        test_async_reset();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
